// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int unsigned NUM_PORTS  = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BURST_LEN  = 4;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set req bit at or after start, wrapping.
module rr_pick #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     start,
  output logic                 found,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IDX_W'((32'(start) + i) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NUM_PORTS writers into one FIFO write port.
// Define FIFO_WR_ARBITER_STATS_EN to add a saturating full-stall counter output.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_PORTS  = fifo_arb_pkg::NUM_PORTS,
  parameter int unsigned DATA_WIDTH = fifo_arb_pkg::DATA_WIDTH,
  parameter int unsigned BURST_LEN  = fifo_arb_pkg::BURST_LEN,
  localparam int unsigned IdxW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
  input  logic                            full,
  output logic [NUM_PORTS-1:0]            ack,
  output logic                            grant_valid,
  output logic [IdxW-1:0]                 grant_idx,
  output logic                            fifo_wr_req,
`ifdef FIFO_WR_ARBITER_STATS_EN
  output logic [15:0]                     stall_cnt,
`endif
  output logic [DATA_WIDTH-1:0]           fifo_data
);

  import fifo_arb_pkg::*;

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  state_e             state_q;
  logic               grant_valid_q;
  logic [IdxW-1:0]    grant_idx_q;
  logic [IdxW-1:0]    last_idx_q;
  logic [CntW-1:0]    burst_cnt_q;

  logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];
  logic                  cur_req;
  logic                  last_word;
  logic                  release_grant;
  logic [IdxW-1:0]       search_start;
  logic                  pick_found;
  logic [IdxW-1:0]       pick_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      port_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // While granted, last_idx equals grant_idx, so one search start serves both IDLE and release.
  always_comb begin
    search_start = (32'(last_idx_q) == NUM_PORTS - 1) ? '0 : last_idx_q + IdxW'(1);
  end

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IdxW)
  ) u_rr_pick (
    .req   (req),
    .start (search_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    cur_req       = req[grant_idx_q];
    fifo_wr_req   = en & grant_valid_q & cur_req & ~full;
    ack           = '0;
    ack[grant_idx_q] = fifo_wr_req;
    fifo_data     = grant_valid_q ? port_data[grant_idx_q] : '0;
    last_word     = fifo_wr_req && (burst_cnt_q == CntW'(BURST_LEN - 1));
    release_grant = last_word || !cur_req;
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      last_idx_q    <= IdxW'(NUM_PORTS - 1);
      burst_cnt_q   <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q       <= GRANT;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= pick_idx;
            last_idx_q    <= pick_idx;
            burst_cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (release_grant) begin
            burst_cnt_q <= '0;
            if (pick_found) begin
              grant_idx_q <= pick_idx;
              last_idx_q  <= pick_idx;
            end else begin
              state_q       <= IDLE;
              grant_valid_q <= 1'b0;
            end
          end else if (fifo_wr_req) begin
            burst_cnt_q <= burst_cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (en && grant_valid_q && cur_req && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
